// File: rtl/io_port_scheduler_if.sv
// IO-controller and peripheral-port signals of the port scheduler.
// The scheduler takes the slave view; the controller/peripheral side takes master.
interface io_port_scheduler_if #(
  parameter int NUM_PORTS = 4
);
  logic [7:0]                  io_cmd;
  logic [7:0]                  io_wdata;
  logic [7:0]                  io_rdata;
  logic                        io_done;
  logic                        busy;
  logic                        irq_any;
  logic [NUM_PORTS-1:0]        dev_req;
  logic                        dev_we;
  logic [7:0]                  dev_wdata;
  logic [NUM_PORTS-1:0][7:0]   dev_rdata;
  logic [NUM_PORTS-1:0]        dev_ack;
  logic [NUM_PORTS-1:0]        dev_irq;

  modport master (
    output io_cmd, io_wdata, dev_rdata, dev_ack, dev_irq,
    input  io_rdata, io_done, busy, irq_any, dev_req, dev_we, dev_wdata
  );

  modport slave (
    input  io_cmd, io_wdata, dev_rdata, dev_ack, dev_irq,
    output io_rdata, io_done, busy, irq_any, dev_req, dev_we, dev_wdata
  );
endinterface

// File: rtl/io_port_scheduler.sv
// Decodes IO-bus commands, runs a req/ack handshake with one peripheral port,
// aborts on timeout, and grants pending interrupts round-robin.
module io_port_scheduler #(
  parameter int NUM_PORTS = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clock,
  input  logic                 reset_n,
  io_port_scheduler_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] OP_READ   = 8'h01;
  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam logic [7:0] OP_STATUS = 8'h03;
  localparam logic [7:0] OP_SELECT = 8'h04;
  localparam logic [7:0] OP_IRQACK = 8'h05;
  localparam logic [1:0] LAST_RST  = 2'(NUM_PORTS - 1);
  localparam logic [2:0] NP        = 3'(NUM_PORTS);
  localparam logic [7:0] TMR_MAX   = 8'(TIMEOUT - 1);

  state_t               state, state_n;
  logic [1:0]           sel, sel_n, last_grant, last_grant_n, grant, irq_idx, sel_new;
  logic                 to_flag, to_flag_n, ovr_flag, ovr_flag_n;
  logic [7:0]           tmr, tmr_n, rdata, rdata_n, wdata, wdata_n;
  logic                 done, done_n, we, we_n, irq_hit, irq_any;
  logic [NUM_PORTS-1:0] req, req_n;

  assign irq_any       = |bus.dev_irq;
  assign bus.irq_any   = irq_any;
  assign bus.busy      = (state != IDLE);
  assign bus.io_rdata  = rdata;
  assign bus.io_done   = done;
  assign bus.dev_req   = req;
  assign bus.dev_we    = we;
  assign bus.dev_wdata = wdata;

  // Scan from the farthest port back to the nearest so the nearest pending one wins.
  always_comb begin
    irq_hit = 1'b0;
    grant   = last_grant;
    irq_idx = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      irq_idx = 2'((int'(last_grant) + i) % NUM_PORTS);
      if (bus.dev_irq[irq_idx]) begin
        irq_hit = 1'b1;
        grant   = irq_idx;
      end
    end
  end

  assign sel_new = ({1'b0, bus.io_wdata[1:0]} < NP) ? bus.io_wdata[1:0] : sel;

  always_comb begin
    state_n      = state;
    sel_n        = sel;
    last_grant_n = last_grant;
    to_flag_n    = to_flag;
    ovr_flag_n   = ovr_flag;
    tmr_n        = tmr;
    rdata_n      = rdata;
    wdata_n      = wdata;
    we_n         = we;
    req_n        = req;
    done_n       = 1'b0;
    case (state)
      IDLE: begin
        case (bus.io_cmd)
          OP_READ, OP_WRITE: begin
            state_n = REQ;
            req_n   = NUM_PORTS'(1) << sel;
            we_n    = (bus.io_cmd == OP_WRITE);
            wdata_n = bus.io_wdata;
            tmr_n   = '0;
          end
          OP_STATUS: begin
            state_n    = DONE;
            done_n     = 1'b1;
            rdata_n    = {to_flag, ovr_flag, irq_any, 3'b000, sel};
            to_flag_n  = 1'b0;
            ovr_flag_n = 1'b0;
          end
          OP_SELECT: begin
            state_n = DONE;
            done_n  = 1'b1;
            sel_n   = sel_new;
            rdata_n = {6'b0, sel_new};
          end
          OP_IRQACK: begin
            state_n = DONE;
            done_n  = 1'b1;
            if (irq_hit) begin
              sel_n        = grant;
              last_grant_n = grant;
              rdata_n      = {6'b0, grant};
            end else begin
              rdata_n = 8'h80;
            end
          end
          default: ;
        endcase
      end
      REQ: begin
        if (bus.dev_ack[sel]) begin
          rdata_n = we ? 8'h00 : bus.dev_rdata[sel];
          req_n   = '0;
          state_n = DONE;
          done_n  = 1'b1;
        end else if (tmr == TMR_MAX) begin
          rdata_n   = 8'hFF;
          req_n     = '0;
          to_flag_n = 1'b1;
          state_n   = DONE;
          done_n    = 1'b1;
        end else begin
          tmr_n = tmr + 8'd1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Commands arriving while busy are dropped but remembered.
    if (state != IDLE && bus.io_cmd != 8'h00) ovr_flag_n = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      sel        <= '0;
      last_grant <= LAST_RST;
      to_flag    <= 1'b0;
      ovr_flag   <= 1'b0;
      tmr        <= '0;
      rdata      <= '0;
      done       <= 1'b0;
      req        <= '0;
      we         <= 1'b0;
      wdata      <= '0;
    end else begin
      state      <= state_n;
      sel        <= sel_n;
      last_grant <= last_grant_n;
      to_flag    <= to_flag_n;
      ovr_flag   <= ovr_flag_n;
      tmr        <= tmr_n;
      rdata      <= rdata_n;
      done       <= done_n;
      req        <= req_n;
      we         <= we_n;
      wdata      <= wdata_n;
    end
  end
endmodule
